imem_boot_ctrl: RTL and testbench
=================================

// Module: imem_boot_ctrl
// PURPOSE
//  Parametrised instruction memory for the pipeline IF stage with a built-in boot loader.
//  After reset it clears itself, then serves registered instruction fetches with stall support.
//  A valid/ready loader channel streams words in from a base address.
//  Misaligned and out-of-range fetches and loads are flagged.
// PARAMETERS
//  PC_W   64  width of pc and ld_base byte addresses
//  IW     32  instruction word width
//  DEPTH  32  number of words; power of two, >=2; AW=$clog2(DEPTH)
// PORTS
//  clk          in   1     clock
//  rst_n        in   1     reset, asynchronous, active-low
//  ld_start     in   1     pulse: begin load at ld_base (sampled in RUN only)
//  ld_base      in   PC_W  byte address of first loaded word
//  ld_valid     in   1     loader word valid
//  ld_data      in   IW    loader word
//  ld_last      in   1     qualifies final word of the stream
//  ld_ready     out  1     loader may transfer (high only in LOAD)
//  ld_done      out  1     1-cycle pulse: last word written
//  ld_err       out  1     1-cycle pulse: bad ld_base or load overflow
//  if_en        in   1     fetch request
//  if_stall     in   1     hold fetch outputs
//  pc           in   PC_W  fetch byte address
//  instruc      out  IW    fetched word (registered)
//  instr_valid  out  1     instruc holds a fetch result
//  fetch_fault  out  1     fetch was misaligned or out of range; instruc=0
//  busy         out  1     high in CLEAR and LOAD
// BEHAVIOUR
//  Reset: state=CLEAR, clr_idx=0, ptr=0, instruc=0, instr_valid=0, fetch_fault=0,
//   ld_done=0, ld_err=0. Async assert, sync release. Reset mid-LOAD abandons the load.
//  CLEAR: writes mem[clr_idx]=0 and increments clr_idx each cycle.
//   After writing index DEPTH-1, goes to RUN; CLEAR takes exactly DEPTH cycles.
//   ld_start and if_en are ignored and not queued during CLEAR.
//  RUN, fetch: idx=pc[AW+1:2]. Bad if pc[1:0]!=0 or pc[PC_W-1:AW+2]!=0.
//   if_stall=1: instruc, instr_valid and fetch_fault hold (stall wins over if_en).
//   if_en=1, stall=0, pc good: next edge instruc=mem[idx], instr_valid=1, fault=0.
//   if_en=1, stall=0, pc bad: next edge instruc=0, instr_valid=1, fault=1.
//   if_en=0, stall=0: next edge instruc=0, instr_valid=0, fault=0.
//   Latency is 1 cycle from pc to instruc.
//  RUN, ld_start=1:
//   ld_base misaligned or out of range: ld_err pulses next cycle; stay in RUN.
//   Otherwise ptr=ld_base[AW+1:2] and go to LOAD.
//   Fetch in that same cycle is still served.
//  LOAD: ld_ready=1 (decoded from state); instruc=0, instr_valid=0, fault=0.
//   A transfer occurs when ld_valid&&ld_ready; it writes mem[ptr]=ld_data and ptr+=1.
//   Transfer with ld_last: ld_done pulses next cycle; go to RUN.
//   Transfer at ptr=DEPTH-1 without ld_last: write it, ld_err pulses next cycle, go to RUN.
//   ptr never wraps. ld_last with ptr=DEPTH-1 is done, not err.
//   ld_start in LOAD is ignored. ld_valid gaps are allowed, with no timeout.
//  The first cycle back in RUN is a normal fetch cycle.
//  No read/write hazard exists, since fetch is disabled while writing.
//  Memory has no reset port; CLEAR provides the zero contents.
// TESTING
//  T1 reset, DEPTH=32: busy=1 for 32 clk, then 0.
//   if_en, pc=0x0: next cycle instruc=0, instr_valid=1.
//  T2 ld_start, base=0x10; send 0xA0000001..03, last on 3rd, with 1-cycle valid gaps.
//   -> ld_done 1 cycle after 3rd transfer; pc=0x14 -> instruc=0xA0000002.
//  T3 pc=0x10 fetched, then if_stall=1 with pc=0x18 for 3 cycles.
//   -> instruc stays 0xA0000001; release stall -> 0xA0000003.
//  T4 pc=0x12 -> fetch_fault=1, instruc=0; pc=0x80 -> fault=1; pc=0x7C -> fault=0.
//  T5 base=0x78, 3 words, no last -> idx 30,31 written, ld_err after 2nd, ld_ready=0 for 3rd.
//   ld_base=0x06 -> ld_err, busy stays 0.
//  T6 rst_n low after 1 of 3 load words -> busy for 32 cycles.
//   -> every address then reads 0, ld_done never pulses.

Source files
------------

// File: rtl/imem_boot_ctrl.sv
// Instruction memory for the IF stage with a self-clearing boot phase and a
// valid/ready loader channel that streams words in from a base address.
module imem_boot_ctrl #(
  parameter int PC_W  = 64,
  parameter int IW    = 32,
  parameter int DEPTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_start,
  input  logic [PC_W-1:0] ld_base,
  input  logic            ld_valid,
  input  logic [IW-1:0]   ld_data,
  input  logic            ld_last,
  output logic            ld_ready,
  output logic            ld_done,
  output logic            ld_err,
  input  logic            if_en,
  input  logic            if_stall,
  input  logic [PC_W-1:0] pc,
  output logic [IW-1:0]   instruc,
  output logic            instr_valid,
  output logic            fetch_fault,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_RUN,
    S_LOAD
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0] clr_idx;
  logic [AW-1:0] ptr;
  logic [IW-1:0] mem [DEPTH];

  logic [AW-1:0] fidx;
  logic [AW-1:0] bidx;
  logic          pc_bad;
  logic          base_bad;
  logic          load_go;
  logic          xfer;
  logic          last_slot;
  logic          we;
  logic [AW-1:0] waddr;
  logic [IW-1:0] wdata;

  // Byte addresses must be word aligned and fall inside the DEPTH-word window.
  assign fidx      = pc[AW+1:2];
  assign bidx      = ld_base[AW+1:2];
  assign pc_bad    = (pc[1:0] != 2'b00) || ((pc >> (AW + 2)) != '0);
  assign base_bad  = (ld_base[1:0] != 2'b00) || ((ld_base >> (AW + 2)) != '0);
  assign load_go   = (state == S_RUN) && ld_start && !base_bad;
  assign xfer      = (state == S_LOAD) && ld_valid;
  assign last_slot = (ptr == AW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_idx == AW'(DEPTH - 1)) state_nxt = S_RUN;
      S_RUN:   if (load_go) state_nxt = S_LOAD;
      S_LOAD:  if (xfer && (ld_last || last_slot)) state_nxt = S_RUN;
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    ld_ready = 1'b0;
    busy     = 1'b0;
    we       = 1'b0;
    waddr    = clr_idx;
    wdata    = '0;
    case (state)
      S_CLEAR: begin
        busy = 1'b1;
        we   = 1'b1;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        we       = ld_valid;
        waddr    = ptr;
        wdata    = ld_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_idx <= '0;
      ptr     <= '0;
    end else begin
      if (state == S_CLEAR) clr_idx <= clr_idx + AW'(1);
      if (load_go) begin
        ptr <= bidx;
      end else if (xfer && !last_slot) begin
        ptr <= ptr + AW'(1);
      end
    end
  end

  // No reset on the array: the CLEAR phase supplies the zero contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruc     <= '0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (state == S_RUN) begin
      if (!if_stall) begin
        if (if_en) begin
          instruc     <= pc_bad ? '0 : mem[fidx];
          instr_valid <= 1'b1;
          fetch_fault <= pc_bad;
        end else begin
          instruc     <= '0;
          instr_valid <= 1'b0;
          fetch_fault <= 1'b0;
        end
      end
    end else begin
      instruc     <= '0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_done <= 1'b0;
      ld_err  <= 1'b0;
    end else begin
      ld_done <= xfer && ld_last;
      ld_err  <= ((state == S_RUN) && ld_start && base_bad) ||
                 (xfer && !ld_last && last_slot);
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: directed sequences, a fetch vector table and
// randomized traffic, all compared against an array-based reference model.
module tb_imem_boot_ctrl;

  localparam int PC_W  = 64;
  localparam int IW    = 32;
  localparam int DEPTH = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ld_start = 1'b0;
  logic [PC_W-1:0] ld_base = '0;
  logic            ld_valid = 1'b0;
  logic [IW-1:0]   ld_data = '0;
  logic            ld_last = 1'b0;
  logic            ld_ready;
  logic            ld_done;
  logic            ld_err;
  logic            if_en = 1'b0;
  logic            if_stall = 1'b0;
  logic [PC_W-1:0] pc = '0;
  logic [IW-1:0]   instruc;
  logic            instr_valid;
  logic            fetch_fault;
  logic            busy;

  imem_boot_ctrl #(.PC_W(PC_W), .IW(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .ld_done(ld_done), .ld_err(ld_err),
    .if_en(if_en), .if_stall(if_stall), .pc(pc),
    .instruc(instruc), .instr_valid(instr_valid), .fetch_fault(fetch_fault),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: words still to clear, a loading flag and write pointer.
  int          clear_left;
  bit          loading;
  int          wp;
  logic [31:0] mm [DEPTH];
  logic [31:0] e_instr;
  bit          e_v, e_f, e_done, e_err;

  typedef struct {
    logic [63:0] pc;
    logic        en;
    logic        st;
    logic [31:0] ei;
    logic        ev;
    logic        ef;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = '0; ld_base = '0;
    if_en = 0; if_stall = 0; pc = '0;
  endtask

  task automatic model_step();
    longint unsigned a;
    e_done = 0;
    e_err  = 0;
    if (clear_left > 0) begin
      mm[DEPTH - clear_left] = '0;
      clear_left--;
      e_instr = '0; e_v = 0; e_f = 0;
    end else if (loading) begin
      e_instr = '0; e_v = 0; e_f = 0;
      if (ld_valid) begin
        mm[wp] = ld_data;
        if (ld_last) begin
          e_done = 1; loading = 0;
        end else if (wp == DEPTH - 1) begin
          e_err = 1; loading = 0;
        end else begin
          wp++;
        end
      end
    end else begin
      if (!if_stall) begin
        if (if_en) begin
          a = pc;
          if (a % 4 != 0 || a >= 4 * DEPTH) begin
            e_instr = '0; e_v = 1; e_f = 1;
          end else begin
            e_instr = mm[int'(a / 4)]; e_v = 1; e_f = 0;
          end
        end else begin
          e_instr = '0; e_v = 0; e_f = 0;
        end
      end
      if (ld_start) begin
        a = ld_base;
        if (a % 4 != 0 || a >= 4 * DEPTH) e_err = 1;
        else begin
          loading = 1; wp = int'(a / 4);
        end
      end
    end
  endtask

  task automatic tick();
    chk("busy", busy, 64'(clear_left > 0 || loading));
    chk("ld_ready", ld_ready, 64'(loading));
    model_step();
    @(posedge clk); #1;
    chk("instruc", instruc, e_instr);
    chk("instr_valid", instr_valid, e_v);
    chk("fetch_fault", fetch_fault, e_f);
    chk("ld_done", ld_done, e_done);
    chk("ld_err", ld_err, e_err);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    clear_left = DEPTH; loading = 0;
    e_instr = '0; e_v = 0; e_f = 0; e_done = 0; e_err = 0;
    chk("rst_instruc", instruc, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_done", ld_done, 0);
    chk("rst_err", ld_err, 0);
    chk("rst_busy", busy, 1);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic fetch(input logic [63:0] a);
    if_en = 1; if_stall = 0; pc = a;
    tick();
    if_en = 0;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    ld_valid = 1; ld_data = d; ld_last = last;
    tick();
    ld_valid = 0; ld_last = 0;
  endtask

  initial begin
    tbl[0] = '{64'h12, 1, 0, 32'h0, 1, 1};
    tbl[1] = '{64'h80, 1, 0, 32'h0, 1, 1};
    tbl[2] = '{64'h7C, 1, 0, 32'h0, 1, 0};
    tbl[3] = '{64'h10, 1, 0, 32'hA0000001, 1, 0};
    tbl[4] = '{64'h12, 1, 1, 32'hA0000001, 1, 0};
    tbl[5] = '{64'h18, 0, 0, 32'h0, 0, 0};
    tbl[6] = '{64'h18, 1, 1, 32'h0, 0, 0};
    tbl[7] = '{64'h14, 1, 0, 32'hA0000002, 1, 0};
    tbl[8] = '{64'h100_0000_0000, 1, 0, 32'h0, 1, 1};
    tbl[9] = '{64'h18, 0, 1, 32'h0, 1, 1};

    idle();
    #1;
    do_reset();

    // T1: clear phase lasts exactly DEPTH cycles
    for (int i = 0; i < DEPTH; i++) begin
      chk("t1_busy_high", busy, 1);
      tick();
    end
    chk("t1_busy_low", busy, 0);
    fetch(64'h0);
    chk("t1_instr", instruc, 0);
    chk("t1_valid", instr_valid, 1);

    // T2: load three words at 0x10 with valid gaps
    ld_start = 1; ld_base = 64'h10;
    tick();
    ld_start = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      load_word(32'hA0000000 + 32'(i), i == 3);
    end
    chk("t2_done", ld_done, 1);
    chk("t2_busy", busy, 0);
    fetch(64'h14);
    chk("t2_instr", instruc, 32'hA0000002);
    chk("t2_done_drop", ld_done, 0);

    // T3: stall holds the previous fetch result
    fetch(64'h10);
    chk("t3_first", instruc, 32'hA0000001);
    if_en = 1; if_stall = 1; pc = 64'h18;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold", instruc, 32'hA0000001);
    end
    if_stall = 0;
    tick();
    chk("t3_release", instruc, 32'hA0000003);
    if_en = 0;

    // T4: fetch vector table
    for (int i = 0; i < 10; i++) begin
      pc = tbl[i].pc; if_en = tbl[i].en; if_stall = tbl[i].st;
      tick();
      chk("tbl_instr", instruc, tbl[i].ei);
      chk("tbl_valid", instr_valid, tbl[i].ev);
      chk("tbl_fault", fetch_fault, tbl[i].ef);
    end
    idle();

    // T5: overflow at the top slot, then a misaligned base
    ld_start = 1; ld_base = 64'h78;
    tick();
    ld_start = 0;
    load_word(32'hC0000030, 0);
    chk("t5_ready_mid", ld_ready, 1);
    load_word(32'hC0000031, 0);
    chk("t5_err", ld_err, 1);
    chk("t5_ready_off", ld_ready, 0);
    load_word(32'hC0000032, 0);
    chk("t5_err_drop", ld_err, 0);
    fetch(64'h78);
    chk("t5_idx30", instruc, 32'hC0000030);
    fetch(64'h7C);
    chk("t5_idx31", instruc, 32'hC0000031);
    fetch(64'h0);
    chk("t5_idx0", instruc, 0);
    ld_start = 1; ld_base = 64'h06;
    tick();
    ld_start = 0;
    chk("t5_bad_base_err", ld_err, 1);
    chk("t5_bad_base_busy", busy, 0);
    ld_start = 1; ld_base = 64'h80;
    tick();
    ld_start = 0;
    chk("t5_range_base_err", ld_err, 1);

    // T6: reset in the middle of a load
    ld_start = 1; ld_base = 64'h0;
    tick();
    ld_start = 0;
    load_word(32'hB0000001, 0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      chk("t6_busy", busy, 1);
      tick();
      chk("t6_no_done", ld_done, 0);
    end
    chk("t6_busy_low", busy, 0);
    for (int i = 0; i < DEPTH; i++) begin
      fetch(64'(4 * i));
      chk("t6_zero", instruc, 0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        idle();
        do_reset();
      end
      ld_start = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 5))
        0:       ld_base = {$urandom, $urandom};
        1:       ld_base = 64'($urandom_range(0, 140));
        default: ld_base = 64'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      ld_valid = $urandom_range(0, 1);
      ld_last  = ($urandom_range(0, 7) == 0);
      ld_data  = $urandom;
      if_en    = ($urandom_range(0, 3) != 0);
      if_stall = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 9))
        0:       pc = {$urandom, $urandom};
        1:       pc = 64'($urandom_range(0, 140));
        default: pc = 64'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
